// File: rtl/idx_codec_pkg.sv
// Shared definitions for the index encoder/decoder pair: sizes, FSM state
// encoding and a saturating counter helper.
package idx_codec_pkg;

    localparam int WIDTH = 8;
    localparam int IDX_W = $clog2(WIDTH);
    localparam int CNT_W = IDX_W + 1;

    // ACCUM collects beats of a frame; HOLD presents the finished frame.
    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/idx_onehot_dec.sv
// Combinational index-to-one-hot decoder. Null beats and indices outside
// the mask width decode to all-zero so they cannot set any mask bit.
module idx_onehot_dec
    import idx_codec_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             is_null,
    output logic [WIDTH-1:0] onehot
);

    // Decode with null/range gating.
    always_comb begin
        onehot = '0;
        if (!is_null && (32'(idx) < 32'(WIDTH))) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/idx_mask_decoder.sv
// Rebuilds a request mask from a stream of encoded indices. Each accepted
// beat produces a registered one-hot pulse; a beat with in_last closes the
// frame and the accumulated mask, non-null beat count and duplicate flag
// are offered on a valid/ready output.
//
// Handshakes: a beat transfers on a rising edge where in_valid && in_ready;
// a frame result transfers on a rising edge where out_valid && out_ready.
// out_valid stays high and the result stays stable until it transfers.
module idx_mask_decoder
    import idx_codec_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             in_null,
    input  logic             in_last,
    output logic             dec_valid,
    output logic [WIDTH-1:0] dec_onehot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mask,
    output logic [CNT_W-1:0] out_count,
    output logic             out_dup
);

    state_t           state;
    logic [WIDTH-1:0] mask_q;
    logic [CNT_W-1:0] count_q;
    logic             dup_q;

    logic [WIDTH-1:0] dec_line;
    logic             accept;
    logic             frame_done;
    logic             result_taken;
    logic [WIDTH-1:0] mask_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             dup_nxt;

    idx_onehot_dec u_dec (
        .idx     (in_idx),
        .is_null (in_null),
        .onehot  (dec_line)
    );

    assign in_ready     = (state == ACCUM);
    assign accept       = in_valid && in_ready;
    assign frame_done   = accept && in_last;
    assign result_taken = (state == HOLD) && out_valid && out_ready;

    // Running totals including the beat currently presented. A duplicate is
    // a decoded bit that was already set before this beat.
    always_comb begin
        mask_nxt  = mask_q | dec_line;
        count_nxt = (|dec_line) ? sat_inc(count_q) : count_q;
        dup_nxt   = dup_q | (|(dec_line & mask_q));
    end

    // Frame state: ACCUM until the last beat, HOLD until the result transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            case (state)
                ACCUM:   if (frame_done)   state <= HOLD;
                HOLD:    if (result_taken) state <= ACCUM;
                default: state <= ACCUM;
            endcase
        end
    end

    // Accumulators: update on every accepted beat, cleared once the
    // finished frame has been handed off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q  <= '0;
            count_q <= '0;
            dup_q   <= 1'b0;
        end else if (result_taken) begin
            mask_q  <= '0;
            count_q <= '0;
            dup_q   <= 1'b0;
        end else if (accept) begin
            mask_q  <= mask_nxt;
            count_q <= count_nxt;
            dup_q   <= dup_nxt;
        end
    end

    // Per-beat pulse: one cycle after each accept; the one-hot value holds
    // between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_valid  <= 1'b0;
            dec_onehot <= '0;
        end else begin
            dec_valid <= accept;
            if (accept) begin
                dec_onehot <= dec_line;
            end
        end
    end

    // Frame result: captured with the last beat folded in; the data fields
    // persist after the handoff until the next frame completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_mask  <= '0;
            out_count <= '0;
            out_dup   <= 1'b0;
        end else if (frame_done) begin
            out_valid <= 1'b1;
            out_mask  <= mask_nxt;
            out_count <= count_nxt;
            out_dup   <= dup_nxt;
        end else if (result_taken) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_idx_mask_decoder.sv
// Directed bench for idx_mask_decoder with a scoreboard for per-beat pulses
// and completed frames.
module tb_idx_mask_decoder;
    import idx_codec_pkg::*;

    localparam int FW = WIDTH + CNT_W + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_idx;
    logic             in_null;
    logic             in_last;
    logic             dec_valid;
    logic [WIDTH-1:0] dec_onehot;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_mask;
    logic [CNT_W-1:0] out_count;
    logic             out_dup;

    idx_mask_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_idx     (in_idx),
        .in_null    (in_null),
        .in_last    (in_last),
        .dec_valid  (dec_valid),
        .dec_onehot (dec_onehot),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mask   (out_mask),
        .out_count  (out_count),
        .out_dup    (out_dup)
    );

    // ---------------- scoreboard ----------------
    logic [WIDTH-1:0] dec_q[$];
    logic [FW-1:0]    frame_q[$];
    int n_cmp = 0;
    int n_err = 0;

    logic [WIDTH-1:0] m_mask;
    logic [CNT_W-1:0] m_count;
    logic             m_dup;
    logic [WIDTH-1:0] mon_dec_exp;
    logic [FW-1:0]    mon_frame_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_mask  = '0;
        m_count = '0;
        m_dup   = 1'b0;
    endtask

    // Monitor: pops expectations when the DUT presents a pulse or a frame
    // that transfers on the coming edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dec_valid) begin
                if (dec_q.size() == 0) begin
                    check("dec_valid_unexpected", 32'(dec_valid), 32'd0);
                end else begin
                    mon_dec_exp = dec_q.pop_front();
                    check("dec_onehot", 32'(dec_onehot), 32'(mon_dec_exp));
                end
            end
            if (out_valid && out_ready) begin
                if (frame_q.size() == 0) begin
                    check("frame_unexpected", 32'(out_valid), 32'd0);
                end else begin
                    mon_frame_exp = frame_q.pop_front();
                    check("frame_result", 32'({out_mask, out_count, out_dup}), 32'(mon_frame_exp));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic [IDX_W-1:0] idx, input logic nul, input logic last);
        logic [WIDTH-1:0] d;
        logic             rdy;
        int               waited;
        in_valid = 1'b1;
        in_idx   = idx;
        in_null  = nul;
        in_last  = last;
        waited   = 0;
        do begin
            rdy = in_ready;
            @(posedge clk);
            waited++;
        end while (!rdy && waited < 50);
        if (!rdy) begin
            check("accept_timeout", 32'(rdy), 32'd1);
        end else begin
            d = '0;
            if (!nul) d[idx] = 1'b1;
            dec_q.push_back(d);
            if (!nul) begin
                m_dup  = m_dup | m_mask[idx];
                m_mask = m_mask | d;
                if (m_count != '1) m_count = m_count + CNT_W'(1);
            end
            if (last) begin
                frame_q.push_back({m_mask, m_count, m_dup});
                model_clear();
            end
        end
        #1;
        in_valid = 1'b0;
        in_null  = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic take_frame();
        logic v;
        int   waited;
        out_ready = 1'b1;
        waited    = 0;
        do begin
            v = out_valid;
            @(posedge clk);
            waited++;
        end while (!v && waited < 50);
        if (!v) check("frame_timeout", 32'(v), 32'd1);
        #1;
        out_ready = 1'b0;
        check("out_valid_drop", 32'(out_valid), 32'd0);
        check("in_ready_after_hs", 32'(in_ready), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_idx    = '0;
        in_null   = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        model_clear();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",   32'(in_ready),   32'd1);
        check("rst_dec_valid",  32'(dec_valid),  32'd0);
        check("rst_dec_onehot", 32'(dec_onehot), 32'd0);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_out_mask",   32'(out_mask),   32'd0);
        check("rst_out_count",  32'(out_count),  32'd0);
        check("rst_out_dup",    32'(out_dup),    32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Mid-frame reset discards the partial frame.
        send_beat(3'd3, 1'b0, 1'b0);
        send_beat(3'd5, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready",  32'(in_ready),   32'd1);
        check("midrst_dec_oh",    32'(dec_onehot), 32'd0);
        check("midrst_out_valid", 32'(out_valid),  32'd0);
        check("midrst_out_mask",  32'(out_mask),   32'd0);
        check("midrst_out_count", 32'(out_count),  32'd0);
        check("midrst_pending",   32'(dec_q.size()), 32'd0);
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_beat(3'd1, 1'b0, 1'b1);
        check("fresh_out_valid", 32'(out_valid), 32'd1);
        take_frame();
        check("fresh_mask_held",  32'(out_mask),  32'h02);
        check("fresh_count_held", 32'(out_count), 32'd1);

        // Sweep 0..7; out_valid one cycle after the last accept.
        for (int i = 0; i < WIDTH; i++) begin
            send_beat(IDX_W'(i), 1'b0, i == WIDTH - 1);
            if (i == WIDTH - 2) check("sweep_no_early_valid", 32'(out_valid), 32'd0);
        end
        check("sweep_out_valid", 32'(out_valid), 32'd1);
        check("sweep_out_mask",  32'(out_mask),  32'hFF);
        take_frame();

        // Duplicate plus a null beat.
        send_beat(3'd2, 1'b0, 1'b0);
        send_beat(3'd0, 1'b1, 1'b0);
        send_beat(3'd2, 1'b0, 1'b0);
        send_beat(3'd6, 1'b0, 1'b1);
        check("dup_out_mask", 32'(out_mask), 32'h44);
        check("dup_out_dup",  32'(out_dup),  32'd1);
        take_frame();

        // Empty frame.
        send_beat(3'd4, 1'b1, 1'b1);
        check("empty_out_valid", 32'(out_valid), 32'd1);
        check("empty_out_mask",  32'(out_mask),  32'd0);
        take_frame();

        // Backpressure: result stable and input blocked.
        send_beat(3'd7, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_idx   = 3'd2;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_mask",  32'(out_mask),  32'h80);
            check("bp_out_count", 32'(out_count), 32'd1);
            check("bp_in_ready",  32'(in_ready),  32'd0);
        end
        in_valid = 1'b0;
        take_frame();

        // Count saturation.
        for (int i = 0; i < 20; i++) begin
            send_beat(3'd3, 1'b0, i == 19);
        end
        check("sat_out_count", 32'(out_count), 32'd15);
        check("sat_out_mask",  32'(out_mask),  32'h08);
        check("sat_out_dup",   32'(out_dup),   32'd1);
        take_frame();

        repeat (3) @(posedge clk);
        #1;
        check("dec_q_drained",   32'(dec_q.size()),   32'd0);
        check("frame_q_drained", 32'(frame_q.size()), 32'd0);

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/idx_mask_decoder.md
Name: idx_mask_decoder

Overview:
- Inverse of the 8-to-3 priority encoder path: rebuilds an 8-bit request mask from a stream of encoded indices (index + valid-style null flag), one index per beat.
- Emits a registered one-hot pulse per accepted beat and a completed mask per frame (frame closed by in_last) through a valid/ready output handshake.
- Sits downstream of the encoder/serialiser so the original mask can be reconstructed.

Parameters:
- WIDTH, 8, mask width / number of decoded lines.
- IDX_W, $clog2(WIDTH) = 3, index width.
- CNT_W, IDX_W+1 = 4, beat-counter width; saturates at 2^CNT_W-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_idx  in  IDX_W  encoded index (bit position).
- in_null  in  1  beat carries no index (encoder valid=0); decodes to all-zero.
- in_last  in  1  final beat of frame.
- dec_valid  out  1  one-cycle pulse, one-hot for the previous accepted beat.
- dec_onehot  out  WIDTH  registered one-hot of last accepted index (0 for null).
- out_valid  out  1  frame result valid.
- out_ready  in  1  consumer accepts frame result.
- out_mask  out  WIDTH  OR of all decoded indices in the frame.
- out_count  out  CNT_W  non-null beats in frame, saturating.
- out_dup  out  1  some index repeated within the frame.

Behaviour:
- Reset (async assert, sync-deasserted externally): state=ACCUM, in_ready=1, dec_valid=0, dec_onehot=0, out_valid=0, out_mask=0, out_count=0, out_dup=0, internal mask/count/dup=0.
- Accept = in_valid && in_ready.
- ACCUM: in_ready=1. On accept with !in_null: mask |= 1<<in_idx; count+=1 (saturating at 15); dup|= mask[in_idx] (old value). On a null beat, mask/count/dup are unchanged.
- dec_valid/dec_onehot: registered, asserted the cycle after each accept (including null beats, onehot=0); dec_valid is low otherwise. dec_onehot holds its last value.
- Accept with in_last: next cycle out_valid=1, out_mask/out_count/out_dup = totals including the last beat; state→HOLD. Latency of last beat to out_valid is 1 cycle.
- HOLD: in_ready=0; outputs stable while out_valid && !out_ready. On out_valid && out_ready: next cycle out_valid=0, internal mask/count/dup cleared, state→ACCUM, so in_ready=1 one cycle after the handshake. out_mask/out_count/out_dup keep their values until the next frame completes.
- Empty frame (single null beat with in_last): out_valid with mask=0, count=0, dup=0.
- Single beat frame (in_last on first non-null beat): mask is one-hot, count=1.
- in_idx is always within range for WIDTH=8. For non-power-of-2 WIDTH, in_idx ≥ WIDTH is treated as null.
- Count saturation: the 16th and later non-null beats leave count=15. Mask and dup still update.
- rst_n asserted mid-frame or in HOLD: everything returns to reset values at once and the partial frame is discarded.
- in_valid while in_ready=0: ignored. The upstream holds the beat.

Decomposition:
- Shared package idx_codec_pkg: WIDTH/IDX_W/CNT_W localparams and a state enum typedef {ACCUM, HOLD}. The encoder bench can reuse it.
- One natural sub-module: idx_onehot_dec (combinational IDX_W→WIDTH decoder with null/range gating), instantiated once. The rest is a flat FSM and datapath.

Test Plan:
- Reset: drive rst_n=0 mid-frame after beats 3,5 → all outputs 0, in_ready=1. A fresh frame {idx 1, last} then gives out_mask=8'b00000010, count=1.
- Sweep: beats idx 0..7 with last on 7 → dec_onehot walks 01,02,…,80 with one dec_valid pulse each; out_mask=8'hFF, count=8, dup=0, out_valid one cycle after the last accept.
- Duplicate/null: beats {2, null, 2, 6+last} → out_mask=8'b01000100, count=3, dup=1; the null beat gives dec_valid=1 with dec_onehot=0.
- Empty frame: one null beat with last → out_valid=1, mask=0, count=0, dup=0. This mirrors encoder input 8'b00000000.
- Backpressure: hold out_ready=0 for 5 cycles after frame {7+last} → out_mask=8'h80 stable, in_ready=0, and in_valid beats are not accepted. On out_ready=1, out_valid drops next cycle and in_ready=1.
- Saturation: 20 beats of idx 3, last on the 20th → count=15, mask=8'h08, dup=1.
